serial_add_ctrl: RTL and testbench

// - Sequencer wrapped around the 4-bit ripple adder (A,B,C0 -> F,C4).
// - Adds two wide operands one nibble per clock, least-significant nibble first.
// - Drives the adder inputs and registers each F nibble into a wide sum.
// - Chains C4 back as the next C0; exposes a start/busy/done handshake to the controller above.

---
 rtl/serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add sequencer driving an external 4-bit ripple adder, LSB nibble first.
// Optional macro SUB_MODE_EN adds an i_sub input that turns the operation into A - B.
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_op_a,
  input  logic [4*NIBBLES-1:0] i_op_b,
  input  logic                 i_cin,
`ifdef SUB_MODE_EN
  input  logic                 i_sub,
`endif
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*NIBBLES-1:0] o_sum,
  output logic                 o_cout,
  output logic [3:0]           o_add_a,
  output logic [3:0]           o_add_b,
  output logic                 o_add_c0,
  input  logic [3:0]           i_add_f,
  input  logic                 i_add_c4
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;

  logic [W-1:0]  w_b_in;
  logic          w_c_in;
  logic [IW+1:0] w_base;

  // Operand conditioning at the accepting edge: subtraction is A + ~B + 1.
  always_comb begin
`ifdef SUB_MODE_EN
    if (i_sub) begin
      w_b_in = ~i_op_b;
      w_c_in = 1'b1;
    end else begin
      w_b_in = i_op_b;
      w_c_in = i_cin;
    end
`else
    w_b_in = i_op_b;
    w_c_in = i_cin;
`endif
  end

  assign w_base = {r_idx, 2'b00};

  // Adder drive is a mux of registered state, held at zero outside RUN.
  always_comb begin
    o_add_a  = 4'h0;
    o_add_b  = 4'h0;
    o_add_c0 = 1'b0;
    if (r_state == S_RUN) begin
      o_add_a  = r_a[w_base +: 4];
      o_add_b  = r_b[w_base +: 4];
      o_add_c0 = r_carry;
    end else begin
      o_add_a  = 4'h0;
      o_add_b  = 4'h0;
      o_add_c0 = 1'b0;
    end
  end

  // Sequencer: latch operands, collect one F nibble per edge, pulse done once.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_state <= S_RUN;
            r_a     <= i_op_a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
            o_sum   <= '0;
            o_busy  <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_RUN: begin
          o_sum[w_base +: 4] <= i_add_f;
          r_carry            <= i_add_c4;
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_idx   <= '0;
            o_cout  <= i_add_c4;
            o_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with an attached 4-bit adder model and a
// whole-word arithmetic reference model; define SUB_MODE_EN to also exercise subtraction.
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_c0;
  logic [3:0]  add_f;
  logic        add_c4;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.NIBBLES(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op_a  (op_a),
    .i_op_b  (op_b),
    .i_cin   (cin),
`ifdef SUB_MODE_EN
    .i_sub   (sub),
`endif
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_add_a (add_a),
    .o_add_b (add_b),
    .o_add_c0(add_c0),
    .i_add_f (add_f),
    .i_add_c4(add_c4)
  );

  assign {add_c4, add_f} = 5'(add_a) + 5'(add_b) + 5'(add_c0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..4 one nibble per cycle, 5 done.
  int          m_phase = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_a, m_b, m_sum;
  logic        m_c, m_cout;
  logic [15:0] eff_b;
  logic        eff_c;

  always_comb begin
`ifdef SUB_MODE_EN
    eff_b = sub ? ~op_b : op_b;
    eff_c = sub ? 1'b1 : cin;
`else
    eff_b = op_b;
    eff_c = cin;
`endif
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_sum   <= 16'h0000;
      m_cout  <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1;
          m_a     <= op_a;
          m_b     <= eff_b;
          m_c     <= eff_c;
        end
      end else if (m_phase < 5) begin
        m_phase <= m_phase + 1;
        if (m_phase == 4) {m_cout, m_sum} <= 17'(m_a) + 17'(m_b) + 17'(m_c);
      end else begin
        m_phase <= 0;
      end
    end
  end

  function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b,
                                      input logic c, input int p);
    logic [16:0] mask;
    logic [16:0] tot;
    mask = (17'd1 << (4 * p)) - 17'd1;
    tot  = (17'(a) & mask) + (17'(b) & mask) + 17'(c);
    return tot[4 * p];
  endfunction

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 5));
      if (m_phase >= 1 && m_phase <= 4) begin
        chk("add_a", 32'(add_a), 32'(m_a[4 * (m_phase - 1) +: 4]));
        chk("add_b", 32'(add_b), 32'(m_b[4 * (m_phase - 1) +: 4]));
        chk("add_c0", 32'(add_c0), 32'(carry_into(m_a, m_b, m_c, m_phase - 1)));
      end else begin
        chk("add_idle", {add_a, add_b, add_c0}, 32'h0);
        chk("sum", 32'(sum), 32'(m_sum));
        chk("cout", 32'(cout), 32'(m_cout));
      end
    end
  end

  // mode 0 plain, 1 extra start pulse on RUN cycle 2, 2 reset on RUN cycle 2.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic c,
                     input logic s, input int mode, output int cyc, output int bcnt,
                     output logic [3:0] c0s, output int dcnt);
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    cyc = 0; bcnt = 0; c0s = 4'h0; dcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (k <= 4) c0s[k - 1] = add_c0;
      if (done) begin
        dcnt++;
        if (cyc == 0) cyc = k;
      end
      start = 1'b0;
      if (k == 2 && mode == 1) begin
        start = 1'b1;
        op_a  = 16'hAAAA;
      end
      if (k == 2 && mode == 2) rst_n = 1'b0;
      if (k == 3 && mode == 2) begin
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sum", 32'(sum), 32'h0);
        rst_n = 1'b1;
      end
    end
  endtask

  int         cyc, bcnt, dcnt;
  logic [3:0] c0s;

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = 16'h0; op_b = 16'h0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, cyc, bcnt, c0s, dcnt);
    chk("wrap_done_cycle", 32'(cyc), 32'd5);
    chk("wrap_sum", 32'(sum), 32'h0000);
    chk("wrap_cout", 32'(cout), 32'h1);

    run(16'h1234, 16'h4321, 1'b1, 1'b0, 0, cyc, bcnt, c0s, dcnt);
    chk("basic_sum", 32'(sum), 32'h5556);
    chk("basic_cout", 32'(cout), 32'h0);
    chk("basic_busy_cycles", 32'(bcnt), 32'd5);

    run(16'h0FFF, 16'h0001, 1'b0, 1'b0, 0, cyc, bcnt, c0s, dcnt);
    chk("ripple_c0_seq", 32'(c0s), 32'hE);
    chk("ripple_sum", 32'(sum), 32'h1000);
    chk("ripple_cout", 32'(cout), 32'h0);

    run(16'h0001, 16'h0001, 1'b0, 1'b0, 1, cyc, bcnt, c0s, dcnt);
    chk("busy_start_sum", 32'(sum), 32'h0002);
    chk("busy_start_dones", 32'(dcnt), 32'd1);

    run(16'h1111, 16'h2222, 1'b0, 1'b0, 2, cyc, bcnt, c0s, dcnt);
    chk("reset_mid_dones", 32'(dcnt), 32'd0);
    run(16'h0003, 16'h0004, 1'b0, 1'b0, 0, cyc, bcnt, c0s, dcnt);
    chk("after_reset_sum", 32'(sum), 32'h0007);

`ifdef SUB_MODE_EN
    run(16'h0005, 16'h0007, 1'b0, 1'b1, 0, cyc, bcnt, c0s, dcnt);
    chk("sub_neg_sum", 32'(sum), 32'hFFFE);
    chk("sub_neg_cout", 32'(cout), 32'h0);
    run(16'h0007, 16'h0005, 1'b0, 1'b1, 0, cyc, bcnt, c0s, dcnt);
    chk("sub_pos_sum", 32'(sum), 32'h0002);
    chk("sub_pos_cout", 32'(cout), 32'h1);
`endif

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      cin   = 1'($urandom);
`ifdef SUB_MODE_EN
      sub   = 1'($urandom);
`endif
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
